// File: rtl/reg_out_serializer.sv
// Serializes a byte captured from a register output as start, 8 data bits LSB-first, optional even parity, stop.
// Define SER_PARITY_EN to compile in the parity bit (11-bit frame); otherwise frames are 10 bits.
module reg_out_serializer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] RegIn,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       sout,
    output logic       busy,
    output logic       done
);

`ifdef SER_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state, state_n;
    logic [7:0] shift, shift_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] div_cnt, div_n;
    logic       wrap;
    logic       sout_n, done_n, ready_n;
`ifdef SER_PARITY_EN
    logic       par, par_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            sout     <= 1'b1;
            done     <= 1'b0;
            tx_ready <= 1'b1;
`ifdef SER_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            bit_cnt  <= bit_n;
            div_cnt  <= div_n;
            sout     <= sout_n;
            done     <= done_n;
            tx_ready <= ready_n;
`ifdef SER_PARITY_EN
            par      <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        shift_n = shift;
        bit_n   = bit_cnt;
        div_n   = div_cnt;
`ifdef SER_PARITY_EN
        par_n   = par;
`endif
        wrap    = (div_cnt == DIV_LAST);

        if (state != IDLE) begin
            div_n = wrap ? '0 : div_cnt + 8'd1;
        end

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    shift_n = RegIn;
                    bit_n   = '0;
                    div_n   = '0;
                    state_n = START;
`ifdef SER_PARITY_EN
                    par_n   = ^RegIn;
`endif
                end
            end
            START: begin
                if (wrap) state_n = DATA;
            end
            DATA: begin
                if (wrap) begin
                    shift_n = {1'b0, shift[7:1]};
                    bit_n   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef SER_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                if (wrap) state_n = STOP;
            end
`endif
            STOP: begin
                if (wrap) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next-state values.
        case (state_n)
            START:   sout_n = 1'b0;
            DATA:    sout_n = shift_n[0];
`ifdef SER_PARITY_EN
            PARITY:  sout_n = par_n;
`endif
            default: sout_n = 1'b1;
        endcase
        done_n  = (state_n == STOP) && (div_n == DIV_LAST);
        ready_n = (state_n == IDLE);
    end

    assign busy = ~tx_ready;

endmodule

// File: doc/reg_out_serializer.md
# reg_out_serializer

Transmit-side companion to the 8-bit register: takes the parallel value presented on a register output, captures it on a valid/ready handshake, and shifts it out LSB-first on a single-wire serial line. The frame is start bit, 8 data bits, optional parity, and stop bit. It sits between the CPU output register and the off-chip/debug serial pin, and is the reader of the register's `RegOut` bus.

## Interface
Parameters:
- `CLK_DIV`, default 4: clock cycles per serial bit; legal range 1..255.

Ports:
- `clk`, input, 1: the only clock; all logic rising-edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `RegIn`, input, 8: parallel data, normally wired to a register's `RegOut`.
- `tx_valid`, input, 1: a value on `RegIn` is offered for transmission.
- `tx_ready`, output, 1: serializer idle and able to accept; a transfer occurs on a rising edge with `tx_valid && tx_ready`.
- `sout`, output, 1: serial line; idles high.
- `busy`, output, 1: a frame is in progress; equals `~tx_ready`.
- `done`, output, 1: one-cycle pulse on the final cycle of the stop bit.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - `sout`=1 and `tx_ready`=1.
  - On accept, capture `RegIn` into the shift register, clear the bit counter and divider, and go to START.
- START: `sout`=0 for `CLK_DIV` cycles, then go to DATA.
- DATA:
  - `sout`=shift[0] for `CLK_DIV` cycles per bit; the register shifts right at the end of each bit.
  - A 3-bit counter counts bits 0..7.
  - After bit 7, go to PARITY if compiled in, otherwise STOP.
- PARITY: `sout`=XOR of the captured byte (even parity) for `CLK_DIV` cycles.
- STOP:
  - `sout`=1 for `CLK_DIV` cycles.
  - `done`=1 on the last of those cycles.
  - Then go to IDLE.
- Captured data is frozen for the whole frame. `RegIn` changes after the accept have no effect.
- `tx_valid` while busy is ignored; no data is captured and nothing is queued.
- Divider: counts 0..`CLK_DIV`-1 and wraps. A bit boundary occurs at the wrap. With `CLK_DIV`=1, every cycle is a bit boundary.
- Reset values: `sout`=1, `tx_ready`=1, `busy`=0, `done`=0, state IDLE, shift register 0, counters 0.
- Reset mid-frame aborts the frame: the line returns high on the cycle after the reset edge and no `done` is issued.
- Reset held together with `tx_valid`: reset wins and no accept occurs.

## Timing
- Accept at edge T. `sout` falls to 0 in the cycle after T (first START cycle).
- Frame length F = 10·`CLK_DIV` cycles without parity, 11·`CLK_DIV` with parity.
- `done` is high during cycle T+F, the last STOP cycle.
- `tx_ready` rises in cycle T+F+1. The earliest next accept is at the edge ending that cycle.
- Back-to-back frames therefore have exactly one idle-high cycle between the end of STOP and the next START.
- All outputs are registered; there is no combinational path from `tx_valid` or `RegIn` to any output.

## Configuration
- Macro `SER_PARITY_EN`.
- Defined:
  - The PARITY state is compiled in and an even-parity bit follows data bit 7.
  - Frame is 11 bits.
- Undefined:
  - PARITY state and parity logic are absent; DATA goes directly to STOP.
  - Frame is 10 bits.
- The bench must run both builds.

## Test plan
- Basic frame, `CLK_DIV`=4, no parity: reset, then accept `RegIn`=8'h01.
  - Required: `sout` bit sequence 0,1,0,0,0,0,0,0,0,1, each bit held 4 cycles.
  - `done` pulses 40 cycles after accept; `tx_ready` is high the following cycle.
- Parity build, `CLK_DIV`=4: send 8'h03, then 8'h07.
  - Required: parity bit 0 for 8'h03 and 1 for 8'h07.
  - `done` at accept+44.
- Walking-one sweep, `CLK_DIV`=1: send 8'h01, 8'h02, 8'h04 … 8'h80 with `tx_valid` held high throughout.
  - Required: each frame decodes to its value.
  - Exactly one idle-high cycle between frames.
- Busy ignore: accept 8'hA5, then during DATA drive `RegIn`=8'h5A with `tx_valid`=1 for 3 cycles.
  - Required: the frame transmits 8'hA5.
  - No second frame starts until `tx_ready` rises.
- Reset mid-frame: assert `rst` for 1 cycle during data bit 3 of 8'hFF.
  - Required: `sout`=1, `tx_ready`=1, `busy`=0 from the next cycle.
  - No `done` pulse.
  - A new accept of 8'h00 then transmits correctly.
- Reset with valid: `rst`=1 and `tx_valid`=1 on the same edge.
  - Required: no frame starts.
  - `sout` stays 1 for 20 cycles after `tx_valid` is dropped.
